// File: rtl/snitch_icache_lookup_arb.sv
// Shares the icache lookup request port between NR_REQ fetch requesters,
// remembers which requester issued each in-flight lookup so responses can be
// steered back in order, and sequences lookup flushes after draining.
module snitch_icache_lookup_arb #(
  parameter int NR_REQ     = 2,
  parameter int FETCH_AW   = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LINE_WIDTH = 128,
  parameter int SET_ALIGN  = 1,
  parameter int MAX_OUTST  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_REQ*FETCH_AW-1:0]   req_addr_i,
  input  logic [NR_REQ*ID_WIDTH-1:0]   req_id_i,
  input  logic [NR_REQ-1:0]            req_valid_i,
  output logic [NR_REQ-1:0]            req_ready_o,
  output logic [LINE_WIDTH-1:0]        rsp_data_o,
  output logic                         rsp_hit_o,
  output logic                         rsp_error_o,
  output logic [SET_ALIGN-1:0]         rsp_set_o,
  output logic [FETCH_AW-1:0]          rsp_addr_o,
  output logic [ID_WIDTH-1:0]          rsp_id_o,
  output logic [NR_REQ-1:0]            rsp_valid_o,
  input  logic [NR_REQ-1:0]            rsp_ready_i,
  output logic [FETCH_AW-1:0]          lk_addr_o,
  output logic [ID_WIDTH-1:0]          lk_id_o,
  output logic                         lk_valid_o,
  input  logic                         lk_ready_i,
  input  logic [FETCH_AW-1:0]          lk_addr_i,
  input  logic [ID_WIDTH-1:0]          lk_id_i,
  input  logic [SET_ALIGN-1:0]         lk_set_i,
  input  logic                         lk_hit_i,
  input  logic [LINE_WIDTH-1:0]        lk_data_i,
  input  logic                         lk_error_i,
  input  logic                         lk_valid_i,
  output logic                         lk_ready_o,
  input  logic                         flush_valid_i,
  output logic                         flush_ready_o,
  output logic                         lk_flush_valid_o,
  input  logic                         lk_flush_ready_i,
  output logic                         busy_o
);

  localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush,
    StDone
  } state_e;

  state_e             state_q;
  logic               flushValid_q;
  logic               flushReady_q;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   cand, candHigh, candLow;
  logic               foundHigh;
  logic               anyValid;
  logic               grantAllowed;
  logic               push, pop;
  logic               fifoNotEmpty;
  logic [IDX_W-1:0]   head;

  // Round-robin pick: lowest valid index at or above rr_q, else lowest valid overall.
  always_comb begin
    candHigh  = '0;
    candLow   = '0;
    foundHigh = 1'b0;
    for (int j = NR_REQ - 1; j >= 0; j--) begin
      if (req_valid_i[j]) begin
        candLow = IDX_W'(j);
        if (j >= int'(rr_q)) begin
          candHigh  = IDX_W'(j);
          foundHigh = 1'b1;
        end
      end
    end
    cand = foundHigh ? candHigh : candLow;
  end

  assign anyValid     = |req_valid_i;
  assign grantAllowed = (state_q == StIdle) && (cnt_q < CNT_W'(MAX_OUTST));
  assign lk_valid_o   = grantAllowed & anyValid;
  assign lk_addr_o    = req_addr_i[cand*FETCH_AW +: FETCH_AW];
  assign lk_id_o      = req_id_i[cand*ID_WIDTH +: ID_WIDTH];
  assign push         = lk_valid_o & lk_ready_i;
  assign fifoNotEmpty = (cnt_q != '0);
  assign lk_ready_o   = fifoNotEmpty & rsp_ready_i[head];
  assign pop          = lk_valid_i & lk_ready_o;

  // Ready goes only to the selected requester; with nothing valid there is no one to accept.
  always_comb begin
    req_ready_o       = '0;
    req_ready_o[cand] = grantAllowed & anyValid & lk_ready_i;
  end

  // Response valid is steered to the requester owning the oldest lookup.
  always_comb begin
    rsp_valid_o = '0;
    if (lk_valid_i && fifoNotEmpty) rsp_valid_o[head] = 1'b1;
  end

  assign rsp_data_o  = lk_data_i;
  assign rsp_hit_o   = lk_hit_i;
  assign rsp_error_o = lk_error_i;
  assign rsp_set_o   = lk_set_i;
  assign rsp_addr_o  = lk_addr_i;
  assign rsp_id_o    = lk_id_i;

  // Next round-robin pointer and outstanding count.
  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (int'(cand) == NR_REQ - 1) ? '0 : cand + IDX_W'(1);
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Arbitration pointer and outstanding-lookup counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (NR_REQ > 1) begin : gIdxFifo
      logic [IDX_W-1:0] fifoMem_q [MAX_OUTST];
      logic [PTR_W-1:0] wrPtr_q, rdPtr_q;

      // Issuing-requester FIFO; emptiness comes from cnt_q so storage needs no reset.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wrPtr_q <= '0;
          rdPtr_q <= '0;
        end else begin
          if (push) begin
            fifoMem_q[wrPtr_q] <= cand;
            wrPtr_q <= (wrPtr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wrPtr_q + PTR_W'(1);
          end
          if (pop) begin
            rdPtr_q <= (rdPtr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rdPtr_q + PTR_W'(1);
          end
        end
      end

      assign head = fifoMem_q[rdPtr_q];
    end else begin : gNoIdx
      assign head = '0;
    end
  endgenerate

  // Flush sequencer: block grants, wait for all lookups to return, then flush the lookup stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      flushValid_q <= 1'b0;
      flushReady_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (flush_valid_i) state_q <= StDrain;
        end
        StDrain: begin
          if (cnt_q == '0 && !push && !pop) begin
            state_q      <= StFlush;
            flushValid_q <= 1'b1;
          end
        end
        StFlush: begin
          if (lk_flush_ready_i) begin
            state_q      <= StDone;
            flushValid_q <= 1'b0;
            flushReady_q <= 1'b1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          flushReady_q <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          flushValid_q <= 1'b0;
          flushReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign lk_flush_valid_o = flushValid_q;
  assign flush_ready_o    = flushReady_q;
  assign busy_o           = (state_q != StIdle) || (cnt_q != '0);

  // A lookup response with nothing outstanding has no owner to route to.
  assert property (@(posedge clk_i) disable iff (rst_i) lk_valid_i |-> (cnt_q != '0));

endmodule

// File: tb/tb_snitch_icache_lookup_arb.sv
// Directed bench for snitch_icache_lookup_arb: requester and lookup-stage
// models drive the DUT, expected responses are queued as stimulus is issued
// and a monitor checks every response handshake against that queue.
module tb_snitch_icache_lookup_arb;

  localparam int NR_REQ = 2;
  localparam int AW     = 32;
  localparam int IW     = 4;
  localparam int LW     = 128;

  typedef struct {
    int           req;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } expT;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [NR_REQ*AW-1:0] req_addr_i = '0;
  logic [NR_REQ*IW-1:0] req_id_i = '0;
  logic [NR_REQ-1:0]    req_valid_i = '0;
  logic [NR_REQ-1:0]    req_ready_o;
  logic [LW-1:0]        rsp_data_o;
  logic                 rsp_hit_o, rsp_error_o;
  logic [0:0]           rsp_set_o;
  logic [AW-1:0]        rsp_addr_o;
  logic [IW-1:0]        rsp_id_o;
  logic [NR_REQ-1:0]    rsp_valid_o;
  logic [NR_REQ-1:0]    rsp_ready_i = '0;
  logic [AW-1:0]        lk_addr_o;
  logic [IW-1:0]        lk_id_o;
  logic                 lk_valid_o;
  logic                 lk_ready_i = 1'b0;
  logic [AW-1:0]        lk_addr_i = '0;
  logic [IW-1:0]        lk_id_i = '0;
  logic [0:0]           lk_set_i = '0;
  logic                 lk_hit_i = 1'b0;
  logic [LW-1:0]        lk_data_i = '0;
  logic                 lk_error_i = 1'b0;
  logic                 lk_valid_i = 1'b0;
  logic                 lk_ready_o;
  logic                 flush_valid_i = 1'b0;
  logic                 flush_ready_o;
  logic                 lk_flush_valid_o;
  logic                 lk_flush_ready_i = 1'b0;
  logic                 busy_o;

  int  vectors = 0;
  int  miscompares = 0;
  bit  rspEnable = 1'b0;
  expT expQ[$];
  logic [AW+IW-1:0] reqQ0[$];
  logic [AW+IW-1:0] reqQ1[$];
  logic [AW+IW-1:0] lkq[$];

  snitch_icache_lookup_arb #(
    .NR_REQ(NR_REQ), .FETCH_AW(AW), .ID_WIDTH(IW), .LINE_WIDTH(LW), .SET_ALIGN(1), .MAX_OUTST(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_addr_i(req_addr_i), .req_id_i(req_id_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_hit_o(rsp_hit_o), .rsp_error_o(rsp_error_o), .rsp_set_o(rsp_set_o),
    .rsp_addr_o(rsp_addr_o), .rsp_id_o(rsp_id_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .lk_addr_o(lk_addr_o), .lk_id_o(lk_id_o), .lk_valid_o(lk_valid_o), .lk_ready_i(lk_ready_i),
    .lk_addr_i(lk_addr_i), .lk_id_i(lk_id_i), .lk_set_i(lk_set_i), .lk_hit_i(lk_hit_i),
    .lk_data_i(lk_data_i), .lk_error_i(lk_error_i), .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .lk_flush_valid_o(lk_flush_valid_o), .lk_flush_ready_i(lk_flush_ready_i), .busy_o(busy_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    if (r == 0) reqQ0.push_back({addr, id});
    else reqQ1.push_back({addr, id});
  endtask

  task automatic expectRsp(input int r, input logic [IW-1:0] id, input logic [AW-1:0] addr);
    expT e;
    e.req = r; e.id = id; e.addr = addr;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      if (expQ.size() == 0 && !busy_o && lkq.size() == 0 && reqQ0.size() == 0 && reqQ1.size() == 0)
        done = 1'b1;
    end
    checkOutput(name, LW'(done), LW'(1));
  endtask

  task automatic waitFlushValid(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (lk_flush_valid_o) seen = 1'b1;
      else tick();
    end
    checkOutput(name, LW'(seen), LW'(1));
  endtask

  // Requester models: hold valid and payload until the DUT accepts each entry.
  always @(posedge clk_i) begin
    if (rst_i) begin
      reqQ0.delete();
      reqQ1.delete();
    end else begin
      if (req_valid_i[0] && req_ready_o[0]) reqQ0.delete(0);
      if (req_valid_i[1] && req_ready_o[1]) reqQ1.delete(0);
    end
    #1;
    req_valid_i = {reqQ1.size() != 0, reqQ0.size() != 0};
    if (reqQ0.size() != 0) begin
      req_addr_i[AW-1:0] = reqQ0[0][AW+IW-1:IW];
      req_id_i[IW-1:0]   = reqQ0[0][IW-1:0];
    end
    if (reqQ1.size() != 0) begin
      req_addr_i[2*AW-1:AW] = reqQ1[0][AW+IW-1:IW];
      req_id_i[2*IW-1:IW]   = reqQ1[0][IW-1:0];
    end
  end

  // Lookup-stage model: answers accepted lookups in order, data derived from the address.
  always @(posedge clk_i) begin
    if (rst_i) lkq.delete();
    else begin
      if (lk_valid_i && lk_ready_o) lkq.delete(0);
      if (lk_valid_o && lk_ready_i) lkq.push_back({lk_addr_o, lk_id_o});
    end
    #1;
    if (rspEnable && lkq.size() != 0) begin
      lk_valid_i = 1'b1;
      lk_addr_i  = lkq[0][AW+IW-1:IW];
      lk_id_i    = lkq[0][IW-1:0];
      lk_data_i  = {4{lk_addr_i}};
      lk_set_i   = lk_addr_i[4];
      lk_hit_i   = 1'b1;
      lk_error_i = 1'b0;
    end else begin
      lk_valid_i = 1'b0;
      lk_addr_i  = '0;
      lk_id_i    = '0;
      lk_data_i  = '0;
      lk_set_i   = '0;
      lk_hit_i   = 1'b0;
      lk_error_i = 1'b0;
    end
  end

  // Monitor: every response handshake is matched against the oldest expected response.
  always @(negedge clk_i) begin
    if (!rst_i && (rsp_valid_o & rsp_ready_i) != '0) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid_o=%b rsp_id_o=%0h with nothing expected", rsp_valid_o, rsp_id_o);
      end else begin
        expT e;
        logic [NR_REQ-1:0] oh;
        e  = expQ.pop_front();
        oh = '0;
        oh[e.req] = 1'b1;
        checkOutput("rsp_route", LW'(rsp_valid_o), LW'(oh));
        checkOutput("rsp_id", LW'(rsp_id_o), LW'(e.id));
        checkOutput("rsp_addr", LW'(rsp_addr_o), LW'(e.addr));
        checkOutput("rsp_data", rsp_data_o, {4{e.addr}});
        checkOutput("rsp_hit_set_err", LW'({rsp_hit_o, rsp_set_o, rsp_error_o}), LW'({1'b1, e.addr[4], 1'b0}));
      end
    end
  end

  // Hard stop so the run always ends even if the DUT wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    checkOutput("reset_req_ready", LW'(req_ready_o), LW'(0));
    checkOutput("reset_lk_valid", LW'(lk_valid_o), LW'(0));
    checkOutput("reset_rsp_valid", LW'(rsp_valid_o), LW'(0));
    checkOutput("reset_lk_ready", LW'(lk_ready_o), LW'(0));
    checkOutput("reset_flush", LW'({lk_flush_valid_o, flush_ready_o}), LW'(0));
    checkOutput("reset_busy", LW'(busy_o), LW'(0));

    $display("[TB] round-robin with immediate responses");
    lk_ready_i  = 1'b1;
    rsp_ready_i = 2'b11;
    rspEnable   = 1'b1;
    applyStimulus(0, 32'h1000, 4'h1);
    applyStimulus(0, 32'h1004, 4'h2);
    applyStimulus(1, 32'h2010, 4'h3);
    applyStimulus(1, 32'h2014, 4'h4);
    expectRsp(0, 4'h1, 32'h1000);
    expectRsp(1, 4'h3, 32'h2010);
    expectRsp(0, 4'h2, 32'h1004);
    expectRsp(1, 4'h4, 32'h2014);
    waitIdle("rr_drain");

    $display("[TB] outstanding limit");
    rsp_ready_i = 2'b00;
    applyStimulus(0, 32'h1100, 4'h5);
    applyStimulus(0, 32'h1104, 4'h6);
    applyStimulus(0, 32'h1118, 4'h7);
    expectRsp(0, 4'h5, 32'h1100);
    expectRsp(0, 4'h6, 32'h1104);
    expectRsp(0, 4'h7, 32'h1118);
    repeat (4) tick();
    checkOutput("limit_req_ready", LW'(req_ready_o), LW'(0));
    checkOutput("limit_lk_valid", LW'(lk_valid_o), LW'(0));
    checkOutput("limit_lk_ready", LW'(lk_ready_o), LW'(0));
    checkOutput("limit_busy", LW'(busy_o), LW'(1));
    repeat (3) tick();
    checkOutput("limit_still_stalled", LW'(req_ready_o), LW'(0));
    rsp_ready_i = 2'b11;
    tick();
    checkOutput("limit_resume", LW'(req_ready_o), LW'(2'b01));
    waitIdle("limit_drain");

    $display("[TB] response backpressure");
    rsp_ready_i = 2'b01;
    applyStimulus(1, 32'h3000, 4'h8);
    expectRsp(1, 4'h8, 32'h3000);
    for (int n = 0; n < 10 && !lk_valid_i; n++) tick();
    checkOutput("bp_rsp_arrived", LW'(lk_valid_i), LW'(1));
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_lk_ready", LW'(lk_ready_o), LW'(0));
      checkOutput("bp_addr_stable", LW'(rsp_addr_o), LW'(32'h3000));
      tick();
    end
    rsp_ready_i = 2'b11;
    waitIdle("bp_drain");

    $display("[TB] flush with lookups in flight");
    rsp_ready_i = 2'b00;
    applyStimulus(0, 32'h4000, 4'h9);
    applyStimulus(1, 32'h5000, 4'hA);
    expectRsp(0, 4'h9, 32'h4000);
    expectRsp(1, 4'hA, 32'h5000);
    repeat (3) tick();
    checkOutput("flush_pre_busy", LW'(busy_o), LW'(1));
    applyStimulus(0, 32'h6000, 4'hB);
    expectRsp(0, 4'hB, 32'h6000);
    flush_valid_i = 1'b1;
    tick();
    checkOutput("drain_no_grant", LW'(req_ready_o), LW'(0));
    checkOutput("drain_no_flush", LW'(lk_flush_valid_o), LW'(0));
    repeat (2) tick();
    checkOutput("drain_no_flush_late", LW'(lk_flush_valid_o), LW'(0));
    checkOutput("drain_no_grant_late", LW'(req_ready_o), LW'(0));
    rsp_ready_i = 2'b11;
    tick();
    waitFlushValid("flush_valid_seen");
    checkOutput("flush_drained", LW'(expQ.size()), LW'(1));
    checkOutput("flush_no_grant", LW'(req_ready_o), LW'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("flush_hold_valid", LW'(lk_flush_valid_o), LW'(1));
      checkOutput("flush_no_done", LW'(flush_ready_o), LW'(0));
    end
    lk_flush_ready_i = 1'b1;
    tick();
    checkOutput("done_pulse", LW'(flush_ready_o), LW'(1));
    checkOutput("done_flush_low", LW'(lk_flush_valid_o), LW'(0));
    checkOutput("done_no_grant", LW'(req_ready_o), LW'(0));
    lk_flush_ready_i = 1'b0;
    flush_valid_i    = 1'b0;
    tick();
    checkOutput("done_single", LW'(flush_ready_o), LW'(0));
    checkOutput("grant_resumes", LW'(req_ready_o), LW'(2'b01));
    waitIdle("flush_drain");

    $display("[TB] reset while flushing");
    flush_valid_i = 1'b1;
    tick();
    waitFlushValid("rst_flush_reached");
    flush_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rst_flush_valid", LW'(lk_flush_valid_o), LW'(0));
    checkOutput("rst_busy", LW'(busy_o), LW'(0));
    applyStimulus(0, 32'h7000, 4'hC);
    applyStimulus(1, 32'h8010, 4'hD);
    expectRsp(0, 4'hC, 32'h7000);
    expectRsp(1, 4'hD, 32'h8010);
    tick();
    checkOutput("rst_rr_zero", LW'(req_ready_o), LW'(2'b01));
    waitIdle("rst_drain");

    checkOutput("exp_queue_empty", LW'(expQ.size()), LW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snitch_icache_lookup_arb.md
Name: snitch_icache_lookup_arb

Overview:
- Sits in front of the icache lookup stage and shares its single request port between NR_REQ fetch requesters (L0 caches, prefetcher).
- Round-robin arbitrates requests and tracks outstanding lookups in order.
- Routes each lookup response back to the requester that issued it.
- Sequences flushes: blocks new grants, drains in-flight lookups, then handshakes the lookup flush port.

Parameters:
- NR_REQ, 2, number of requesters (>=1)
- FETCH_AW, 32, fetch address width
- ID_WIDTH, 4, per-requester transaction ID width
- LINE_WIDTH, 128, cache line width
- SET_ALIGN, 1, set index width
- MAX_OUTST, 2, maximum lookups in flight (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_addr_i  in  NR_REQ*FETCH_AW  per-requester fetch address
- req_id_i  in  NR_REQ*ID_WIDTH  per-requester ID
- req_valid_i  in  NR_REQ  request valid
- req_ready_o  out  NR_REQ  request accepted
- rsp_data_o  out  LINE_WIDTH  broadcast line data
- rsp_hit_o / rsp_error_o  out  1 each  broadcast hit / error
- rsp_set_o  out  SET_ALIGN  broadcast hit set
- rsp_addr_o  out  FETCH_AW  broadcast address
- rsp_id_o  out  ID_WIDTH  broadcast ID
- rsp_valid_o  out  NR_REQ  one-hot response valid
- rsp_ready_i  in  NR_REQ  response ready
- lk_addr_o / lk_id_o / lk_valid_o  out  FETCH_AW / ID_WIDTH / 1  to lookup input
- lk_ready_i  in  1  lookup input ready
- lk_addr_i / lk_id_i / lk_set_i / lk_hit_i / lk_data_i / lk_error_i / lk_valid_i  in  per lookup output widths  lookup output
- lk_ready_o  out  1  lookup output ready
- flush_valid_i  in  1  flush request
- flush_ready_o  out  1  flush done, one-cycle pulse
- lk_flush_valid_o  out  1  lookup flush request
- lk_flush_ready_i  in  1  lookup flush acknowledge
- busy_o  out  1  flush in progress or lookups outstanding

Behaviour:
- Reset: one clock (clk_i); reset is synchronous and active-high (rst_i). rr_q=0, cnt_q=0, FIFO empty, state=IDLE. All outputs 0 in the cycle following reset; lk_ready_o=0.
- Arbitration, combinational: candidate = first valid index at or after rr_q, wrapping. Grant allowed only when state==IDLE and cnt_q<MAX_OUTST. Pushes are not gated by a same-cycle pop.
- lk_valid_o = grant_allowed & |req_valid_i. lk_addr_o/lk_id_o = candidate's address/ID. req_ready_o[candidate] = grant_allowed & lk_ready_i; all other bits 0.
- On accept (lk_valid_o & lk_ready_i): push candidate index into the tracking FIFO (depth MAX_OUTST); rr_q <= (candidate+1) mod NR_REQ. rr_q is unchanged when no request is accepted.
- Requesters hold valid and payload stable until ready. Candidate selection is stable while rr_q is unchanged.
- Response routing: head = FIFO head. rsp_valid_o = lk_valid_i ? onehot(head) : 0. lk_ready_o = FIFO non-empty & rsp_ready_i[head]. Broadcast fields pass through combinationally.
- Pop: on lk_valid_i & lk_ready_o.
- cnt_q: +1 on push, -1 on pop, unchanged when both occur in the same cycle.
- Error: lk_valid_i with an empty FIFO is a protocol error (assertion); lk_ready_o=0 in that case.
- Flush FSM:
  - IDLE -> DRAIN when flush_valid_i. Grants are blocked from the next cycle. A request accepted in the same cycle as flush_valid_i still counts.
  - DRAIN -> FLUSH when cnt_q==0 and no push/pop this cycle. Responses continue to be served during DRAIN.
  - FLUSH: lk_flush_valid_o=1. -> DONE on lk_flush_ready_i.
  - DONE: flush_ready_o=1 for exactly one cycle; -> IDLE.
  - flush_valid_i is ignored outside IDLE. Requesters drop flush_valid_i after flush_ready_o.
- busy_o = (state!=IDLE) | (cnt_q!=0).
- Reset mid-flush or with lookups outstanding returns to IDLE, clears the FIFO, and drops lk_flush_valid_o next cycle. Responses in flight are discarded.
- NR_REQ==1: rr_q is constant 0 and the FIFO stores no index bits; only cnt_q is kept.

Test Plan:
- Round-robin: NR_REQ=2, both valid continuously, lk_ready_i=1, responses immediate -> grants alternate 0,1,0,1. Each rsp_valid_o pulse goes to the issuing requester with matching rsp_id_o.
- Outstanding limit: MAX_OUTST=2, lk_ready_o held 0 -> third request stalls (req_ready_o=0) until one response pops. cnt_q never exceeds 2.
- Backpressure: response for requester 1 with rsp_ready_i[1]=0 for 5 cycles -> lk_ready_o=0 throughout; data stable; pop on cycle 6.
- Flush drain: 2 lookups outstanding, flush_valid_i=1 -> no grants. lk_flush_valid_o rises only after cnt_q==0. lk_flush_ready_i after 3 cycles -> flush_ready_o single pulse, grants resume next cycle.
- Simultaneous push and pop at cnt_q=1 -> cnt_q stays 1; FIFO order preserved: requester 0 response then requester 1 response.
- Reset in FLUSH state -> lk_flush_valid_o=0, busy_o=0, rr_q=0 next cycle.
